// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control unit.
// A Moore FSM that steps the shared-ALU / unified-memory datapath through one
// micro-step per clock. The three memory-access states (FETCH, MEM_READ,
// MEM_WRITE) are held for MEM_LATENCY+1 cycles by a wait counter. All control
// outputs are registered: they are decoded from the next state and next count,
// so each output is valid for the whole cycle spent in a state. The four write
// enables are additionally gated by reset so that an aborted instruction
// cannot write anything while reset is held.
module multi_cycle_control #(
    parameter int MEM_LATENCY = 0,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opCode,
    output logic        pcWrite,
    output logic        branchEq,
    output logic        branchNe,
    output logic        iorD,
    output logic        memRead,
    output logic        memWrite,
    output logic        irWrite,
    output logic        memtoReg,
    output logic        regDst,
    output logic        regWrite,
    output logic        aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [1:0]  aluOp,
    output logic [1:0]  pcSource,
    output logic        halted,
    output logic [31:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    // Count value reached in the final cycle of a memory-access state.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY);

    // One bundle for every control output so they can be decoded and
    // registered together.
    typedef struct packed {
        logic       pc_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       memto_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       halted;
    } ctrl_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_retired;
    ctrl_t            r_ctrl;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_retire;
    logic             w_mem_state;
    logic             w_last;

    // Moore output decode for a given state / wait count. opCode only matters
    // in BRANCH, where the IR already holds the branch instruction.
    function automatic ctrl_t decode(input state_t s, input logic [CNT_W-1:0] c,
                                     input logic [5:0] op);
        ctrl_t d;
        d = '0;
        case (s)
            S_FETCH: begin
                d.mem_read  = 1'b1;
                d.alu_src_b = 2'b01;
                // PC+4 and IR load only once the instruction word is valid.
                if (c == LAST_CNT) begin
                    d.pc_write = 1'b1;
                    d.ir_write = 1'b1;
                end
            end
            S_DECODE: begin
                d.alu_src_b = 2'b11;
            end
            S_MEM_ADDR: begin
                d.alu_src_a = 1'b1;
                d.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                d.mem_read = 1'b1;
                d.ior_d    = 1'b1;
            end
            S_MEM_WB: begin
                d.reg_write = 1'b1;
                d.memto_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                d.ior_d = 1'b1;
                // A single strobe per store, in the last wait cycle.
                if (c == LAST_CNT) begin
                    d.mem_write = 1'b1;
                end
            end
            S_EXECUTE: begin
                d.alu_src_a = 1'b1;
                d.alu_op    = 2'b10;
            end
            S_R_WB: begin
                d.reg_write = 1'b1;
                d.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                d.alu_src_a = 1'b1;
                d.alu_op    = 2'b01;
                d.pc_source = 2'b01;
                d.branch_eq = (op == OP_BEQ);
                d.branch_ne = (op == OP_BNE);
            end
            S_JUMP: begin
                d.pc_write  = 1'b1;
                d.pc_source = 2'b10;
            end
            S_ADDI_EX: begin
                d.alu_src_a = 1'b1;
                d.alu_src_b = 2'b10;
            end
            S_ADDI_WB: begin
                d.reg_write = 1'b1;
            end
            S_HALT: begin
                d.halted = 1'b1;
            end
            default: begin
                d = '0;
            end
        endcase
        return d;
    endfunction

    // Next-state, wait-counter and retire-event logic.
    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        w_mem_state  = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                       (r_state == S_MEM_WRITE);
        w_last       = (r_cnt == LAST_CNT);
        // Counter runs only while waiting in a memory state; any state
        // change (or any other state) leaves it at zero for the next entry.
        w_cnt_next   = (w_mem_state && !w_last) ? r_cnt + 1'b1 : '0;

        case (r_state)
            S_FETCH: begin
                if (w_last) begin
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opCode)
                    OP_LW, OP_SW:   w_state_next = S_MEM_ADDR;
                    OP_R:           w_state_next = S_EXECUTE;
                    OP_BEQ, OP_BNE: w_state_next = S_BRANCH;
                    OP_J:           w_state_next = S_JUMP;
                    OP_ADDI:        w_state_next = S_ADDI_EX;
                    default:        w_state_next = S_HALT;
                endcase
            end
            S_MEM_ADDR: begin
                w_state_next = (opCode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                if (w_last) begin
                    w_state_next = S_MEM_WB;
                end
            end
            S_MEM_WRITE: begin
                if (w_last) begin
                    w_state_next = S_FETCH;
                    w_retire     = 1'b1;
                end
            end
            S_EXECUTE: begin
                w_state_next = S_R_WB;
            end
            S_ADDI_EX: begin
                w_state_next = S_ADDI_WB;
            end
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                w_state_next = S_FETCH;
                w_retire     = 1'b1;
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    // State, counter, retired count and registered control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_retired <= '0;
            r_ctrl    <= decode(S_FETCH, '0, opCode);
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_retire) begin
                r_retired <= r_retired + 32'd1;
            end
            r_ctrl  <= decode(w_state_next, w_cnt_next, opCode);
        end
    end

    // Write enables are masked by reset so a mid-instruction reset never
    // commits a PC, IR, memory or register-file write.
    assign pcWrite  = r_ctrl.pc_write  & ~reset;
    assign irWrite  = r_ctrl.ir_write  & ~reset;
    assign memWrite = r_ctrl.mem_write & ~reset;
    assign regWrite = r_ctrl.reg_write & ~reset;

    assign branchEq = r_ctrl.branch_eq;
    assign branchNe = r_ctrl.branch_ne;
    assign iorD     = r_ctrl.ior_d;
    assign memRead  = r_ctrl.mem_read;
    assign memtoReg = r_ctrl.memto_reg;
    assign regDst   = r_ctrl.reg_dst;
    assign aluSrcA  = r_ctrl.alu_src_a;
    assign aluSrcB  = r_ctrl.alu_src_b;
    assign aluOp    = r_ctrl.alu_op;
    assign pcSource = r_ctrl.pc_source;
    assign halted   = r_ctrl.halted;
    assign retired  = r_retired;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Testbench for multi_cycle_control. Two instances run with MEM_LATENCY 0
// and 2. The driver pushes the hand-derived control word and retired count
// expected for every cycle into a per-instance queue; a monitor on the
// falling edge pops and compares whatever is queued.
module tb_multi_cycle_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rst;
    logic [1:0][5:0]   opc;
    logic [1:0][17:0]  act;
    logic [1:0][31:0]  ret;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic        pcWrite, branchEq, branchNe, iorD, memRead, memWrite;
        logic        irWrite, memtoReg, regDst, regWrite, aluSrcA, halted;
        logic [1:0]  aluSrcB, aluOp, pcSource;
        logic [31:0] retired;

        multi_cycle_control #(.MEM_LATENCY(gi * 2), .CNT_W(4)) u_dut (
            .clk      (clk),
            .reset    (rst[gi]),
            .opCode   (opc[gi]),
            .pcWrite  (pcWrite),
            .branchEq (branchEq),
            .branchNe (branchNe),
            .iorD     (iorD),
            .memRead  (memRead),
            .memWrite (memWrite),
            .irWrite  (irWrite),
            .memtoReg (memtoReg),
            .regDst   (regDst),
            .regWrite (regWrite),
            .aluSrcA  (aluSrcA),
            .aluSrcB  (aluSrcB),
            .aluOp    (aluOp),
            .pcSource (pcSource),
            .halted   (halted),
            .retired  (retired)
        );

        assign act[gi] = {pcWrite, branchEq, branchNe, iorD, memRead, memWrite,
                          irWrite, memtoReg, regDst, regWrite, aluSrcA,
                          aluSrcB, aluOp, pcSource, halted};
        assign ret[gi] = retired;
    end

    // Control-word bit positions, MSB first in the order packed above.
    localparam logic [17:0] PCW  = 18'h1 << 17;
    localparam logic [17:0] BEQ  = 18'h1 << 16;
    localparam logic [17:0] BNE  = 18'h1 << 15;
    localparam logic [17:0] IORD = 18'h1 << 14;
    localparam logic [17:0] MRD  = 18'h1 << 13;
    localparam logic [17:0] MWR  = 18'h1 << 12;
    localparam logic [17:0] IRW  = 18'h1 << 11;
    localparam logic [17:0] M2R  = 18'h1 << 10;
    localparam logic [17:0] RDST = 18'h1 << 9;
    localparam logic [17:0] RGW  = 18'h1 << 8;
    localparam logic [17:0] ASA  = 18'h1 << 7;
    localparam logic [17:0] SB01 = 18'd1 << 5;
    localparam logic [17:0] SB10 = 18'd2 << 5;
    localparam logic [17:0] SB11 = 18'd3 << 5;
    localparam logic [17:0] OP01 = 18'd1 << 3;
    localparam logic [17:0] OP10 = 18'd2 << 3;
    localparam logic [17:0] PS01 = 18'd1 << 1;
    localparam logic [17:0] PS10 = 18'd2 << 1;
    localparam logic [17:0] HLT  = 18'd1;

    // Expected control word per micro-step.
    localparam logic [17:0] E_FETCH_W = MRD | SB01;
    localparam logic [17:0] E_FETCH_F = MRD | SB01 | PCW | IRW;
    localparam logic [17:0] E_DECODE  = SB11;
    localparam logic [17:0] E_MADDR   = ASA | SB10;
    localparam logic [17:0] E_MREAD   = MRD | IORD;
    localparam logic [17:0] E_MWB     = RGW | M2R;
    localparam logic [17:0] E_MWR_W   = IORD;
    localparam logic [17:0] E_MWR_F   = IORD | MWR;
    localparam logic [17:0] E_EXEC    = ASA | OP10;
    localparam logic [17:0] E_RWB     = RGW | RDST;
    localparam logic [17:0] E_BEQ     = ASA | OP01 | PS01 | BEQ;
    localparam logic [17:0] E_BNE     = ASA | OP01 | PS01 | BNE;
    localparam logic [17:0] E_JUMP    = PCW | PS10;
    localparam logic [17:0] E_AEX     = ASA | SB10;
    localparam logic [17:0] E_AWB     = RGW;
    localparam logic [17:0] E_HALT    = HLT;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct packed {
        logic [17:0] ctrl;
        logic [31:0] ret;
        int          tag;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] exp_ret[2];
    int          step;
    int          checks;
    int          errors;
    int          mw_cnt[2];

    // Compare one queued expectation against the live outputs.
    task automatic check(input int k, input exp_t e);
        checks++;
        if (act[k] !== e.ctrl || ret[k] !== e.ret) begin
            errors++;
            $display("FAIL dut%0d step %0d ctrl act=%b exp=%b retired act=%0d exp=%0d",
                     k, e.tag, act[k], e.ctrl, ret[k], e.ret);
        end
    endtask

    // Monitor: falling edge, away from the active clock edge.
    always @(negedge clk) begin
        if (q0.size() > 0) check(0, q0.pop_front());
        if (q1.size() > 0) check(1, q1.pop_front());
        if (act[0][12] === 1'b1) mw_cnt[0]++;
        if (act[1][12] === 1'b1) mw_cnt[1]++;
    end

    // Advance one clock, drive reset for that cycle, queue its expectation.
    task automatic cyc(input int k, input logic r, input logic [17:0] c);
        exp_t e;
        @(posedge clk);
        #1;
        rst[k] = r;
        e.ctrl = c;
        e.ret  = exp_ret[k];
        e.tag  = step;
        step++;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Queue the full micro-step sequence of one instruction.
    task automatic instr(input int k, input int lat, input logic [5:0] op);
        $display("dut%0d lat=%0d issue opcode %b at step %0d retired=%0d",
                 k, lat, op, step, exp_ret[k]);
        for (int i = 0; i <= lat; i++) begin
            cyc(k, 1'b0, (i == lat) ? E_FETCH_F : E_FETCH_W);
            if (i == 0) opc[k] = op;
        end
        cyc(k, 1'b0, E_DECODE);
        case (op)
            OP_LW: begin
                cyc(k, 1'b0, E_MADDR);
                for (int i = 0; i <= lat; i++) cyc(k, 1'b0, E_MREAD);
                cyc(k, 1'b0, E_MWB);
            end
            OP_SW: begin
                cyc(k, 1'b0, E_MADDR);
                for (int i = 0; i <= lat; i++)
                    cyc(k, 1'b0, (i == lat) ? E_MWR_F : E_MWR_W);
            end
            OP_R: begin
                cyc(k, 1'b0, E_EXEC);
                cyc(k, 1'b0, E_RWB);
            end
            OP_ADDI: begin
                cyc(k, 1'b0, E_AEX);
                cyc(k, 1'b0, E_AWB);
            end
            OP_BEQ: cyc(k, 1'b0, E_BEQ);
            OP_BNE: cyc(k, 1'b0, E_BNE);
            OP_J:   cyc(k, 1'b0, E_JUMP);
            default: begin
                for (int i = 0; i < 12; i++) cyc(k, 1'b0, E_HALT);
                return;
            end
        endcase
        exp_ret[k] = exp_ret[k] + 32'd1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at step %0d", step);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 2'b11;
        opc        = '0;
        exp_ret[0] = '0;
        exp_ret[1] = '0;
        step       = 0;
        checks     = 0;
        errors     = 0;
        mw_cnt[0]  = 0;
        mw_cnt[1]  = 0;
        repeat (3) @(posedge clk);

        // ---- MEM_LATENCY = 0 ----
        // Reset held: FETCH final cycle, but pcWrite/irWrite masked.
        cyc(0, 1'b1, E_FETCH_W);
        instr(0, 0, OP_LW);
        instr(0, 0, OP_R);
        instr(0, 0, OP_ADDI);
        instr(0, 0, OP_SW);
        instr(0, 0, OP_BEQ);
        instr(0, 0, OP_J);
        instr(0, 0, OP_BNE);
        instr(0, 0, OP_BAD);
        // Reset pulse out of HALT: registered HALT word still visible.
        cyc(0, 1'b1, E_HALT);
        exp_ret[0] = '0;
        instr(0, 0, OP_ADDI);
        @(negedge clk);
        #1;
        rst[0] = 1'b1;

        // ---- MEM_LATENCY = 2 ----
        cyc(1, 1'b1, E_FETCH_W);
        instr(1, 2, OP_LW);
        instr(1, 2, OP_SW);
        // Store aborted by reset in its second MEM_WRITE cycle.
        $display("dut1 lat=2 issue opcode %b with reset in MEM_WRITE at step %0d",
                 OP_SW, step);
        cyc(1, 1'b0, E_FETCH_W);
        opc[1] = OP_SW;
        cyc(1, 1'b0, E_FETCH_W);
        cyc(1, 1'b0, E_FETCH_F);
        cyc(1, 1'b0, E_DECODE);
        cyc(1, 1'b0, E_MADDR);
        cyc(1, 1'b0, E_MWR_W);
        cyc(1, 1'b1, E_MWR_W);
        exp_ret[1] = '0;
        instr(1, 2, OP_LW);
        instr(1, 2, OP_BNE);

        @(negedge clk);
        #1;

        // Every queued expectation consumed, one store strobe per DUT.
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL queue_drain left act=%0d/%0d exp=0/0", q0.size(), q1.size());
        end
        checks++;
        if (mw_cnt[0] != 1) begin
            errors++;
            $display("FAIL memwrite_pulses dut0 act=%0d exp=1", mw_cnt[0]);
        end
        checks++;
        if (mw_cnt[1] != 1) begin
            errors++;
            $display("FAIL memwrite_pulses dut1 act=%0d exp=1", mw_cnt[1]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Moore FSM that sequences a multi-cycle MIPS datapath: one shared ALU, one unified instruction/data memory, and IR/MDR/A/B/ALUOut holding registers.
- Replaces the combinational main decoder of the single-cycle core. It drives every mux select and write enable, one micro-step per clock.
- Supports R-type, lw, sw, beq, bne, addi and j. The memory latency is configurable through a wait counter.

Parameters:
- MEM_LATENCY, 0, number of extra wait cycles held in each memory-access state (FETCH, MEM_READ, MEM_WRITE).
- CNT_W, 4, width of the wait counter. Must satisfy 2^CNT_W > MEM_LATENCY.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- opCode  input  6  IR[31:26]. Stable from DECODE until the instruction completes, because the IR holds it.
- pcWrite  output  1  unconditional PC load
- branchEq  output  1  PC load if ALU zero (datapath ANDs with zero)
- branchNe  output  1  PC load if not zero
- iorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- memRead  output  1  memory read strobe
- memWrite  output  1  memory write strobe
- irWrite  output  1  IR load
- memtoReg  output  1  register write data select: 0 = ALUOut, 1 = MDR
- regDst  output  1  destination register select: 0 = rt, 1 = rd
- regWrite  output  1  register file write enable
- aluSrcA  output  1  ALU A select: 0 = PC, 1 = A
- aluSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- aluOp  output  2  00 = add, 01 = sub, 10 = funct
- pcSource  output  2  PC source select: 00 = ALU, 01 = ALUOut, 10 = jump target
- halted  output  1  illegal opcode trapped
- retired  output  32  count of completed instructions

Behaviour:
State encoding:
- FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, HALT=12.

Opcodes:
- R = 000000, lw = 100011, sw = 101011, beq = 000100, bne = 000101, addi = 001000, j = 000010.

Transitions:
- FETCH -> DECODE.
- DECODE branches on opcode:
  - lw/sw -> MEM_ADDR
  - R -> EXECUTE
  - beq/bne -> BRANCH
  - j -> JUMP
  - addi -> ADDI_EX
  - any other opcode -> HALT
- MEM_ADDR -> MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ -> MEM_WB.
- EXECUTE -> R_WB.
- ADDI_EX -> ADDI_WB.
- MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB -> FETCH.
- HALT stays in HALT until reset.

Wait counter:
- FETCH, MEM_READ and MEM_WRITE each last MEM_LATENCY+1 cycles.
- The counter clears to 0 on entry and increments each cycle.
- The state advances when the counter equals MEM_LATENCY.
- With MEM_LATENCY=0 every state lasts one cycle.

Outputs (any output not listed is 0):
- FETCH: memRead=1, aluSrcB=01. pcWrite=1 and irWrite=1 only in the final cycle.
- DECODE: aluSrcB=11.
- MEM_ADDR: aluSrcA=1, aluSrcB=10.
- MEM_READ: memRead=1, iorD=1 for all cycles.
- MEM_WB: regWrite=1, memtoReg=1.
- MEM_WRITE: iorD=1. memWrite=1 only in the final cycle, giving exactly one write per sw.
- EXECUTE: aluSrcA=1, aluOp=10.
- R_WB: regWrite=1, regDst=1.
- BRANCH: aluSrcA=1, aluOp=01, pcSource=01. branchEq=1 if opCode is beq; branchNe=1 if opCode is bne.
- JUMP: pcWrite=1, pcSource=10.
- ADDI_EX: aluSrcA=1, aluSrcB=10.
- ADDI_WB: regWrite=1.
- HALT: halted=1; all enables 0.

retired counter:
- Increments by 1 on each transition from a terminal state into FETCH.
- Wraps modulo 2^32.
- Does not increment on entry to HALT.

Reset:
- On the clk edge with reset=1: state <= FETCH, wait counter <= 0, retired <= 0.
- While reset=1, pcWrite, irWrite, memWrite and regWrite are forced to 0 combinationally. Reset asserted mid-instruction therefore produces no stray writes.
- The first cycle after deassertion is FETCH count 0.

Test Plan:
- MEM_LATENCY=0: reset, then lw -> states 0,1,2,3,4,0. memRead high in cycles 1 and 4. regWrite=1, memtoReg=1 in cycle 5. retired=1 after 5 cycles.
- MEM_LATENCY=0: sequence R-type, addi, sw, beq, j -> durations 4,4,4,3,3 cycles. Exactly one memWrite pulse. branchEq=1 only in the BRANCH cycle. pcWrite with pcSource=10 in JUMP. retired=5.
- MEM_LATENCY=2: lw -> FETCH held 3 cycles with irWrite/pcWrite only in the 3rd, MEM_READ held 3 cycles; total 9 cycles. sw -> total 8 cycles, with memWrite high only in the last MEM_WRITE cycle.
- bne with opCode=000101 -> BRANCH asserts branchNe=1, branchEq=0, aluOp=01.
- Illegal opcode 111111 -> DECODE -> HALT. halted=1 persists for 10+ cycles with all enables 0 and retired unchanged. A reset pulse returns to FETCH with halted=0 and retired=0.
- MEM_LATENCY=2: reset asserted in the 2nd MEM_WRITE cycle -> memWrite stays 0 throughout. Next state is FETCH count 0 and no write is observed at memory.
